// File: rtl/fdiv_12.sv
// fdiv_12: iterative divider for the 12-bit float format {sign, exp[4:0] bias 15, mant[5:0] with hidden one}.
// Latency: normal result 9 edges after the accept edge (8 quotient bits + normalise); zero operands 1 edge.
// Backpressure: result and flag held in DONE until ready_i; ready_o is high only in IDLE, so there is no overlap.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o       operand handshake; data_1_i = dividend, data_2_i = divisor
//   valid_o / ready_i       result handshake; data_div_o = quotient, div_by_zero_o = divisor was zero
module fdiv_12 #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 6,
  parameter int BIAS   = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [EXP_W+MANT_W:0]     data_1_i,
  input  logic [EXP_W+MANT_W:0]     data_2_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [EXP_W+MANT_W:0]     data_div_o,
  output logic                      div_by_zero_o
);

  localparam int W     = 1 + EXP_W + MANT_W;
  localparam int EW    = EXP_W + 2;          // signed working exponent, covers -16..46
  localparam int Q_W   = MANT_W + 2;         // quotient bits produced
  localparam int CNT_W = $clog2(Q_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_NORM = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(Q_W - 1);
  localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
  localparam logic [MANT_W-1:0]    MANT_ONES = '1;

  logic [1:0]              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    sign_q;
  logic signed [EW-1:0]    exp_q;
  logic [MANT_W+1:0]       rem_q;    // partial remainder, one bit wider than the divisor
  logic [MANT_W:0]         dvsr_q;   // {1, mb}
  logic [Q_W-1:0]          quo_q;

  // Operand decode. Sign is ignored for zero detection; exponent 0 is still a normal number.
  logic                    a_zero, b_zero, sign_in;
  logic [EXP_W-1:0]        ea, eb;
  logic signed [EW-1:0]    exp_in;

  assign a_zero  = (data_1_i[W-2:0] == '0);
  assign b_zero  = (data_2_i[W-2:0] == '0);
  assign sign_in = data_1_i[W-1] ^ data_2_i[W-1];
  assign ea      = data_1_i[W-2 -: EXP_W];
  assign eb      = data_2_i[W-2 -: EXP_W];
  // Two's-complement wraparound in EW bits gives the signed result directly.
  assign exp_in  = EW'({2'b00, ea}) - EW'({2'b00, eb}) + EW'(BIAS);

  // One restoring-division step: subtract if it fits, then shift for the next bit.
  logic                    q_bit;
  logic [MANT_W+1:0]       rem_sel;
  logic [MANT_W+1:0]       rem_nxt;

  assign q_bit   = (rem_q >= {1'b0, dvsr_q});
  assign rem_sel = q_bit ? (rem_q - {1'b0, dvsr_q}) : rem_q;
  // rem_sel < divisor < 2^(MANT_W+1), so its top bit is always zero and can be dropped.
  assign rem_nxt = {rem_sel[MANT_W:0], 1'b0};

  // Normalisation: quotient lies in [2^(Q_W-2), 2^Q_W), so at most one left shift is needed.
  logic [MANT_W-1:0]       mant_n;
  logic signed [EW-1:0]    exp_n;
  logic [W-1:0]            norm_res;

  always_comb begin
    mant_n   = '0;
    exp_n    = exp_q;
    norm_res = '0;
    if (quo_q[Q_W-1]) begin
      mant_n = quo_q[Q_W-2:1];
      exp_n  = exp_q;
    end else begin
      mant_n = quo_q[Q_W-3:0];
      exp_n  = exp_q - EW'(1);
    end
    if (exp_n >= EXP_MAX) begin
      norm_res = {sign_q, EXP_ONES, MANT_ONES};
    end else if (exp_n[EW-1] || (exp_n == '0)) begin
      norm_res = '0;
    end else begin
      norm_res = {sign_q, exp_n[EXP_W-1:0], mant_n};
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = (state_q == ST_DONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      rem_q         <= '0;
      dvsr_q        <= '0;
      quo_q         <= '0;
      data_div_o    <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            sign_q <= sign_in;
            exp_q  <= exp_in;
            rem_q  <= {1'b0, 1'b1, data_1_i[MANT_W-1:0]};
            dvsr_q <= {1'b1, data_2_i[MANT_W-1:0]};
            quo_q  <= '0;
            cnt_q  <= '0;
            if (a_zero || b_zero) begin
              // Zero operands bypass the datapath; x/0 saturates, 0/0 and 0/x give zero.
              state_q       <= ST_DONE;
              div_by_zero_o <= b_zero;
              data_div_o    <= (b_zero && !a_zero) ? {sign_in, EXP_ONES, MANT_ONES} : '0;
            end else begin
              state_q <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[Q_W-2:0], q_bit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_NORM;
          end
        end
        ST_NORM: begin
          data_div_o <= norm_res;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          // data_div_o is deliberately left alone so the last result stays visible.
          if (ready_i) begin
            state_q       <= ST_IDLE;
            div_by_zero_o <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
